// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared encodings for the Salamander control sequencer:
// FSM states, opcodes and small opcode helpers.
package cpu_pkg;

  localparam logic [2:0] OPC_ADD   = 3'd0;
  localparam logic [2:0] OPC_SUB   = 3'd1;
  localparam logic [2:0] OPC_AND   = 3'd2;
  localparam logic [2:0] OPC_OR    = 3'd3;
  localparam logic [2:0] OPC_LOAD  = 3'd4;
  localparam logic [2:0] OPC_STORE = 3'd5;
  localparam logic [2:0] OPC_JZ    = 3'd6;
  localparam logic [2:0] OPC_HALT  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = OPC_ADD,
    OP_SUB   = OPC_SUB,
    OP_AND   = OPC_AND,
    OP_OR    = OPC_OR,
    OP_LOAD  = OPC_LOAD,
    OP_STORE = OPC_STORE,
    OP_JZ    = OPC_JZ,
    OP_HALT  = OPC_HALT
  } opcode_t;

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Program-memory fetch handshake: request/address out,
// acknowledge/data back in the same cycle.
interface cpu_ctrl_seq_if #(
  parameter int PC_SIZE    = 5,
  parameter int INSTR_SIZE = 8
);
  logic                  imem_req_o;
  logic [PC_SIZE-1:0]    imem_addr_o;
  logic                  imem_ack_i;
  logic [INSTR_SIZE-1:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface

// File: rtl/cpu_ctrl_seq_pc_unit.sv
// Program counter: clear beats load beats increment.
// at_max flags the last addressable instruction.
module pc_unit #(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inc,
  input  logic            load,
  input  logic            clr,
  input  logic [SIZE-1:0] load_val,
  output logic [SIZE-1:0] cnt_val,
  output logic            at_max
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_val <= '0;
    end else if (clr) begin
      cnt_val <= '0;
    end else if (load) begin
      cnt_val <= load_val;
    end else if (inc) begin
      cnt_val <= cnt_val + 1'b1;
    end
  end

  assign at_max = &cnt_val;

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Five-state fetch/decode/exec/write-back sequencer; sole
// source of PC, ALU, accumulator and register-file enables.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int PC_SIZE      = 5,
  parameter int INSTR_SIZE   = 8,
  parameter int OPC_SIZE     = 3,
  parameter int RF_ADDR_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    run_i,
  cpu_ctrl_seq_if.master          mem,
  input  logic                    acc_zero_i,
  output logic [OPC_SIZE-1:0]     alu_op_o,
  output logic                    alu_ce_o,
  output logic                    acc_we_o,
  output logic [RF_ADDR_SIZE-1:0] rf_addr_o,
  output logic                    rf_we_o,
  output logic [PC_SIZE-1:0]      pc_o,
  output logic [2:0]              state_o,
  output logic                    halted_o
);

  state_t                  state_q;
  state_t                  state_n;
  logic [INSTR_SIZE-1:0]   ir_q;
  logic                    last_q;
  logic [OPC_SIZE-1:0]     alu_op_q;
  logic [RF_ADDR_SIZE-1:0] rf_addr_q;

  logic                    pc_inc;
  logic                    pc_load;
  logic                    pc_clr;
  logic                    pc_max;
  logic [PC_SIZE-1:0]      pc;
  logic                    fetch_done;
  logic                    decode;

  logic                    acc_op;
  logic                    is_store;
  logic                    is_jz;
  logic                    is_halt;
  logic                    jz_taken;

  pc_unit #(
    .SIZE (PC_SIZE)
  ) u_pc (
    .clk      (clk),
    .rstn     (rstn),
    .inc      (pc_inc),
    .load     (pc_load),
    .clr      (pc_clr),
    .load_val (ir_q[PC_SIZE-1:0]),
    .cnt_val  (pc),
    .at_max   (pc_max)
  );

  // Execution decodes from the latched opcode, never from IR
  assign acc_op   = alu_op_q <= OPC_SIZE'(OPC_LOAD);
  assign is_store = alu_op_q == OPC_SIZE'(OPC_STORE);
  assign is_jz    = alu_op_q == OPC_SIZE'(OPC_JZ);
  assign is_halt  = alu_op_q == OPC_SIZE'(OPC_HALT);
  assign jz_taken = is_jz && acc_zero_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      last_q    <= 1'b0;
      alu_op_q  <= '0;
      rf_addr_q <= '0;
    end else begin
      state_q <= state_n;
      if (fetch_done) begin
        ir_q   <= mem.imem_data_i;
        last_q <= pc_max;
      end
      if (decode) begin
        alu_op_q  <= ir_q[INSTR_SIZE-1 -: OPC_SIZE];
        rf_addr_q <= ir_q[RF_ADDR_SIZE-1:0];
      end
    end
  end

  always_comb begin
    state_n    = state_q;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_clr     = 1'b0;
    fetch_done = 1'b0;
    decode     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run_i) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.imem_ack_i) begin
          fetch_done = 1'b1;
          pc_inc     = 1'b1;
          state_n    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        decode  = 1'b1;
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        unique case (1'b1)
          acc_op, is_store: state_n = ST_WB;
          is_halt:          state_n = ST_IDLE;
          jz_taken: begin
            pc_load = 1'b1;
            state_n = ST_FETCH;
          end
          default: begin
            // untaken JZ ends here; last slot stops, no wrap
            pc_clr  = last_q;
            state_n = last_q ? ST_IDLE : ST_FETCH;
          end
        endcase
      end
      ST_WB: begin
        pc_clr  = last_q;
        state_n = last_q ? ST_IDLE : ST_FETCH;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign mem.imem_req_o  = state_q == ST_FETCH;
  assign mem.imem_addr_o = pc;

  assign alu_op_o  = alu_op_q;
  assign rf_addr_o = rf_addr_q;
  assign alu_ce_o  = (state_q == ST_EXEC) && acc_op;
  assign acc_we_o  = (state_q == ST_WB) && acc_op;
  assign rf_we_o   = (state_q == ST_WB) && is_store;
  assign pc_o      = pc;
  assign state_o   = state_q;
  assign halted_o  = state_q == ST_IDLE;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: directed instruction table, reset
// abort sequence, and random programs vs an ISA-level model.
module tb_cpu_ctrl_seq;

  localparam int PS = 5;
  localparam int IS = 8;
  localparam int OS = 3;
  localparam int RS = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          run_i = 1'b0;
  logic          acc_zero_i = 1'b0;
  logic [OS-1:0] alu_op_o;
  logic          alu_ce_o;
  logic          acc_we_o;
  logic [RS-1:0] rf_addr_o;
  logic          rf_we_o;
  logic [PS-1:0] pc_o;
  logic [2:0]    state_o;
  logic          halted_o;

  cpu_ctrl_seq_if #(.PC_SIZE(PS), .INSTR_SIZE(IS)) mem_if ();

  cpu_ctrl_seq #(
    .PC_SIZE      (PS),
    .INSTR_SIZE   (IS),
    .OPC_SIZE     (OS),
    .RF_ADDR_SIZE (RS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .run_i      (run_i),
    .mem        (mem_if),
    .acc_zero_i (acc_zero_i),
    .alu_op_o   (alu_op_o),
    .alu_ce_o   (alu_ce_o),
    .acc_we_o   (acc_we_o),
    .rf_addr_o  (rf_addr_o),
    .rf_we_o    (rf_we_o),
    .pc_o       (pc_o),
    .state_o    (state_o),
    .halted_o   (halted_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int instr;
    int waits;
    int zero;
    int cycles;
    int ce;
    int acc;
    int rf;
    int pc;
    int halt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  bit idle_b  = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pulses();
    return int'({alu_ce_o, acc_we_o, rf_we_o});
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, int'(mem_if.imem_req_o), 0);
    check({tag, "_addr"}, int'(mem_if.imem_addr_o), 0);
    check({tag, "_alu_op"}, int'(alu_op_o), 0);
    check({tag, "_rf_addr"}, int'(rf_addr_o), 0);
    check({tag, "_pulses"}, pulses(), 0);
    check({tag, "_pc"}, int'(pc_o), 0);
    check({tag, "_state"}, int'(state_o), 0);
    check({tag, "_halted"}, int'(halted_o), 1);
  endtask

  // One instruction: optional run pulse, fetch with waits, then
  // the fixed tail; instruction boundary checked at the end.
  task automatic run_instr(input vec_t v, input bit noise);
    int rem;
    int ep;
    if (idle_b) begin
      run_i = 1'b1;
      tick();
      run_i = 1'b0;
    end
    for (int w = 0; w <= v.waits; w++) begin
      check("fetch_req", int'(mem_if.imem_req_o), 1);
      check("fetch_addr", int'(mem_if.imem_addr_o), v.addr);
      check("fetch_pulses", pulses(), 0);
      if (noise) run_i = 1'($urandom_range(0, 1));
      mem_if.imem_ack_i  = (w == v.waits);
      mem_if.imem_data_i = (w == v.waits) ? 8'(v.instr) : 8'($urandom);
      if (w == v.waits) acc_zero_i = 1'(v.zero);
      tick();
    end
    mem_if.imem_ack_i = 1'b0;
    rem = v.cycles - v.waits - 1;
    for (int i = 0; i < rem; i++) begin
      check("tail_req", int'(mem_if.imem_req_o), 0);
      ep = ((v.ce != 0 && i == 1) ? 4 : 0)
         | ((v.acc != 0 && i == 2) ? 2 : 0)
         | ((v.rf != 0 && i == 2) ? 1 : 0);
      check($sformatf("pulses_c%0d_i%02h", i, v.instr), pulses(), ep);
      if (noise) begin
        run_i              = 1'($urandom_range(0, 1));
        mem_if.imem_ack_i  = 1'($urandom_range(0, 1));
        mem_if.imem_data_i = 8'($urandom);
      end
      tick();
    end
    run_i = 1'b0;
    mem_if.imem_ack_i = 1'b0;
    check("end_state", int'(state_o), v.halt != 0 ? 0 : 1);
    check("end_halted", int'(halted_o), v.halt);
    check($sformatf("end_pc_i%02h", v.instr), int'(pc_o), v.pc);
    check("alu_op", int'(alu_op_o), (v.instr >> 5) & 7);
    check("rf_addr", int'(rf_addr_o), v.instr & 3);
    idle_b = v.halt != 0;
  endtask

  vec_t tbl[15];
  logic [7:0] rom[32];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mpc;
    int op;
    int nxt;
    vec_t v;

    mem_if.imem_ack_i  = 1'b0;
    mem_if.imem_data_i = '0;

    tbl = '{
      '{0,  'h01, 0, 0, 4, 1, 1, 0, 1,  0},
      '{1,  'h22, 3, 0, 7, 1, 1, 0, 2,  0},
      '{2,  'hD4, 0, 1, 3, 0, 0, 0, 20, 0},
      '{20, 'hC5, 0, 0, 3, 0, 0, 0, 21, 0},
      '{21, 'hA3, 1, 0, 5, 0, 0, 1, 22, 0},
      '{22, 'h80, 0, 1, 4, 1, 1, 0, 23, 0},
      '{23, 'hC3, 2, 1, 5, 0, 0, 0, 3,  0},
      '{3,  'hE0, 0, 0, 3, 0, 0, 0, 4,  1},
      '{4,  'h62, 1, 0, 5, 1, 1, 0, 5,  0},
      '{5,  'hDF, 0, 1, 3, 0, 0, 0, 31, 0},
      '{31, 'hA1, 0, 0, 4, 0, 0, 1, 0,  1},
      '{0,  'hDF, 0, 1, 3, 0, 0, 0, 31, 0},
      '{31, 'hC7, 0, 1, 3, 0, 0, 0, 7,  0},
      '{7,  'h43, 2, 0, 6, 1, 1, 0, 8,  0},
      '{8,  'hD0, 0, 0, 3, 0, 0, 0, 9,  0}
    };

    tick();
    check_reset_vals("rst_held");
    tick();
    rstn = 1'b1;
    tick();
    check_reset_vals("post_rst");
    tick();
    check("idle_hold", int'(halted_o), 1);

    idle_b = 1'b1;
    foreach (tbl[k]) run_instr(tbl[k], 1'b0);

    // Reset in the middle of a fetch wait
    check("abort_req_pre", int'(mem_if.imem_req_o), 1);
    check("abort_addr_pre", int'(mem_if.imem_addr_o), 9);
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("abort");
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_hold_pulses", pulses(), 0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_idle", int'(halted_o), 1);
      check("abort_idle_pulses", pulses(), 0);
    end

    // Random programs against an instruction-level model
    for (int k = 0; k < 32; k++) rom[k] = 8'($urandom);
    mpc = 0;
    idle_b = 1'b1;
    repeat (250) begin
      op  = int'(rom[mpc][7:5]);
      nxt = (mpc + 1) % 32;
      v.addr   = mpc;
      v.instr  = int'(rom[mpc]);
      v.waits  = $urandom_range(0, 3);
      v.zero   = $urandom_range(0, 1);
      v.ce     = (op <= 4) ? 1 : 0;
      v.acc    = (op <= 4) ? 1 : 0;
      v.rf     = (op == 5) ? 1 : 0;
      v.cycles = ((op <= 5) ? 4 : 3) + v.waits;
      if (op == 6 && v.zero != 0) begin
        v.pc = v.instr & 31;
        v.halt = 0;
      end else if (op == 7) begin
        v.pc = nxt;
        v.halt = 1;
      end else if (mpc == 31) begin
        v.pc = 0;
        v.halt = 1;
      end else begin
        v.pc = nxt;
        v.halt = 0;
      end
      run_instr(v, 1'b1);
      mpc = v.pc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
